// File: rtl/ctrl_pipe_if.sv
// Control-pipeline bus between the decode side and the pipeline control registers.
// The master drives ID-stage inputs; the slave (ctrl_pipe) returns the per-stage controls.
interface ctrl_pipe_if;
    logic [7:0]  ctrl_id;
    logic        valid_id;
    logic [4:0]  rd_id;
    logic [4:0]  rs1_id;
    logic [4:0]  rs2_id;
    logic        stall_in;
    logic        flush_ex;

    logic        alusrc_ex;
    logic [1:0]  aluop_ex;
    logic        branch_ex;
    logic        memread_mem;
    logic        memwrite_mem;
    logic        memtoreg_wb;
    logic        regwrite_wb;
    logic        valid_ex;
    logic        valid_mem;
    logic        valid_wb;
    logic [4:0]  rd_ex;
    logic [4:0]  rd_mem;
    logic [4:0]  rd_wb;
    logic        stall_id;
    logic [15:0] bubble_cnt;

    modport master (
        output ctrl_id, valid_id, rd_id, rs1_id, rs2_id, stall_in, flush_ex,
        input  alusrc_ex, aluop_ex, branch_ex, memread_mem, memwrite_mem,
               memtoreg_wb, regwrite_wb, valid_ex, valid_mem, valid_wb,
               rd_ex, rd_mem, rd_wb, stall_id, bubble_cnt
    );

    modport slave (
        input  ctrl_id, valid_id, rd_id, rs1_id, rs2_id, stall_in, flush_ex,
        output alusrc_ex, aluop_ex, branch_ex, memread_mem, memwrite_mem,
               memtoreg_wb, regwrite_wb, valid_ex, valid_mem, valid_wb,
               rd_ex, rd_mem, rd_wb, stall_id, bubble_cnt
    );
endinterface

// File: rtl/ctrl_pipe.sv
// ID/EX, EX/MEM, MEM/WB control-word pipeline with bubble insertion, flush and stall.
// Define CTRL_PIPE_HAZARD_EN to add internal load-use hazard detection.
module ctrl_pipe (
    input  logic         clk,
    input  logic         rst,
    ctrl_pipe_if.slave   bus
);

    typedef struct packed {
        logic [7:0] ctrl;   // [7] alusrc [6] memtoreg [5] regwrite [4] memread [3] memwrite [2] branch [1:0] aluop
        logic       valid;
        logic [4:0] rd;
    } stage_t;

    localparam stage_t STAGE_EMPTY = '0;

    stage_t      id_ex_q,  id_ex_d;
    stage_t      ex_mem_q, ex_mem_d;
    stage_t      mem_wb_q, mem_wb_d;
    logic [15:0] bubble_cnt_q, bubble_cnt_d;

    logic        hazard;
    logic        stall_cond;
    logic        bubble;

`ifdef CTRL_PIPE_HAZARD_EN
    // A load sitting in EX whose destination is read by the ID instruction.
    assign hazard = id_ex_q.valid & id_ex_q.ctrl[4] & (id_ex_q.rd != 5'd0) & bus.valid_id &
                    ((id_ex_q.rd == bus.rs1_id) | (id_ex_q.rd == bus.rs2_id));
`else
    assign hazard = 1'b0;
    logic unused_src;
    assign unused_src = ^{bus.rs1_id, bus.rs2_id};
`endif

    assign stall_cond = bus.stall_in | hazard;
    // Flush wins over a stall but both insert exactly one bubble.
    assign bubble     = bus.flush_ex | stall_cond;

    always_comb begin
        // NOTE: every always_comb output is given a default first so no path leaves it unassigned (no latch).
        id_ex_d      = STAGE_EMPTY;
        ex_mem_d     = id_ex_q;
        mem_wb_d     = ex_mem_q;
        bubble_cnt_d = bubble_cnt_q;

        if (!bubble) begin
            id_ex_d.ctrl  = bus.valid_id ? bus.ctrl_id : 8'h00;
            id_ex_d.valid = bus.valid_id;
            id_ex_d.rd    = bus.rd_id;
        end

        if (bubble && (bubble_cnt_q != 16'hFFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 16'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_ex_q      <= STAGE_EMPTY;
            ex_mem_q     <= STAGE_EMPTY;
            mem_wb_q     <= STAGE_EMPTY;
            bubble_cnt_q <= 16'd0;
        end else begin
            id_ex_q      <= id_ex_d;
            ex_mem_q     <= ex_mem_d;
            mem_wb_q     <= mem_wb_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    // Stage outputs come straight from the pipeline registers.
    assign bus.alusrc_ex    = id_ex_q.ctrl[7];
    assign bus.branch_ex    = id_ex_q.ctrl[2];
    assign bus.aluop_ex     = id_ex_q.ctrl[1:0];
    assign bus.valid_ex     = id_ex_q.valid;
    assign bus.rd_ex        = id_ex_q.rd;

    assign bus.memread_mem  = ex_mem_q.ctrl[4];
    assign bus.memwrite_mem = ex_mem_q.ctrl[3];
    assign bus.valid_mem    = ex_mem_q.valid;
    assign bus.rd_mem       = ex_mem_q.rd;

    assign bus.memtoreg_wb  = mem_wb_q.ctrl[6];
    assign bus.regwrite_wb  = mem_wb_q.ctrl[5];
    assign bus.valid_wb     = mem_wb_q.valid;
    assign bus.rd_wb        = mem_wb_q.rd;

    assign bus.bubble_cnt   = bubble_cnt_q;

    // Held low during reset so the front end never freezes on a stale request.
    assign bus.stall_id     = stall_cond & ~bus.flush_ex & ~rst;

    // Control bits that travel with the word but are consumed in other stages.
    logic unused_ctrl;
    assign unused_ctrl = ^{id_ex_q.ctrl[6:3], ex_mem_q.ctrl[7:5], ex_mem_q.ctrl[2:0],
                           mem_wb_q.ctrl[7], mem_wb_q.ctrl[4:0]};

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: history-based model compared every cycle plus directed literal checks.
// Load-use expectations follow CTRL_PIPE_HAZARD_EN when it is defined.
module tb_ctrl_pipe;

`ifdef CTRL_PIPE_HAZARD_EN
    localparam bit HZ = 1'b1;
`else
    localparam bit HZ = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ctrl_pipe_if pif ();

    ctrl_pipe dut (
        .clk (clk),
        .rst (rst),
        .bus (pif)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: what entered the pipe on each of the last three clocks, newest first.
    typedef struct packed {
        logic [7:0] ctrl;
        logic       valid;
        logic [4:0] rd;
    } ent_t;

    ent_t hist [3] = '{default: '0};
    int   m_cnt   = 0;

    function automatic bit m_hazard();
        if (!HZ) return 1'b0;
        return hist[0].valid && hist[0].ctrl[4] && (hist[0].rd != 5'd0) && pif.valid_id &&
               ((hist[0].rd == pif.rs1_id) || (hist[0].rd == pif.rs2_id));
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hist  = '{default: '0};
            m_cnt = 0;
        end else begin
            ent_t e;
            bit   bub;
            bub = pif.flush_ex || pif.stall_in || m_hazard();
            e   = '0;
            if (!bub) begin
                e.ctrl  = pif.valid_id ? pif.ctrl_id : 8'h00;
                e.valid = pif.valid_id;
                e.rd    = pif.rd_id;
            end
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = e;
            if (bub && m_cnt < 65535) m_cnt++;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("m_ex_ctrl", {pif.alusrc_ex, pif.branch_ex, pif.aluop_ex},
                  {hist[0].ctrl[7], hist[0].ctrl[2], hist[0].ctrl[1:0]});
            check("m_ex_vr",   {pif.valid_ex, pif.rd_ex},   {hist[0].valid, hist[0].rd});
            check("m_mem_ctrl", {pif.memread_mem, pif.memwrite_mem}, {hist[1].ctrl[4], hist[1].ctrl[3]});
            check("m_mem_vr",  {pif.valid_mem, pif.rd_mem}, {hist[1].valid, hist[1].rd});
            check("m_wb_ctrl", {pif.memtoreg_wb, pif.regwrite_wb}, {hist[2].ctrl[6], hist[2].ctrl[5]});
            check("m_wb_vr",   {pif.valid_wb, pif.rd_wb},   {hist[2].valid, hist[2].rd});
            check("m_bubble_cnt", pif.bubble_cnt, m_cnt);
            check("m_stall_id", pif.stall_id,
                  rst ? 1'b0 : ((pif.stall_in || m_hazard()) && !pif.flush_ex));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] c, input logic v, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2);
        pif.ctrl_id  = c;
        pif.valid_id = v;
        pif.rd_id    = rd;
        pif.rs1_id   = rs1;
        pif.rs2_id   = rs2;
    endtask

    task automatic idle();
        drive(8'h00, 1'b0, 5'd0, 5'd0, 5'd0);
        pif.stall_in = 1'b0;
        pif.flush_ex = 1'b0;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        idle();
        step();
        step();
        rst = 1'b0;
    endtask

    int cnt_before;

    initial begin
        idle();
        pif.stall_in = 1'b1;
        #2;
        cmp_en = 1'b1;
        check("rst_stall_id", pif.stall_id, 1'b0);
        check("rst_valid", {pif.valid_ex, pif.valid_mem, pif.valid_wb}, 3'b000);
        check("rst_bubble_cnt", pif.bubble_cnt, 16'd0);
        reset_dut();

        // Propagation of a load through all three stages; invalid ID word with junk ctrl follows.
        drive(8'hF0, 1'b1, 5'd5, 5'd0, 5'd0);
        step();
        drive(8'hFF, 1'b0, 5'd0, 5'd0, 5'd0);
        check("prop_alusrc_ex", pif.alusrc_ex, 1'b1);
        check("prop_rd_ex", pif.rd_ex, 5'd5);
        step();
        idle();
        check("prop_memread_mem", pif.memread_mem, 1'b1);
        check("prop_rd_mem", pif.rd_mem, 5'd5);
        check("prop_invalid_masked", {pif.valid_ex, pif.alusrc_ex, pif.aluop_ex}, 4'b0000);
        step();
        check("prop_wb", {pif.memtoreg_wb, pif.regwrite_wb, pif.rd_wb}, {1'b1, 1'b1, 5'd5});

        // Unknown opcode 8'h00 is still a valid instruction.
        drive(8'h00, 1'b1, 5'd9, 5'd0, 5'd0);
        step();
        idle();
        check("nop_valid_ex", {pif.valid_ex, pif.rd_ex}, {1'b1, 5'd9});

        // Load-use on rd=3.
        reset_dut();
        drive(8'hF0, 1'b1, 5'd3, 5'd0, 5'd0);
        step();
        drive(8'h22, 1'b1, 5'd4, 5'd3, 5'd0);
        #1;
        check("lu_stall_id", pif.stall_id, HZ);
        step();
        check("lu_bubble_ex", pif.valid_ex, !HZ);
        check("lu_bubble_cnt", pif.bubble_cnt, HZ);
        check("lu_stall_released", pif.stall_id, 1'b0);
        step();
        idle();
        check("lu_issue", {pif.valid_ex, pif.rd_ex}, {1'b1, 5'd4});

        // Same pattern with rd=0 never stalls.
        reset_dut();
        drive(8'hF0, 1'b1, 5'd0, 5'd0, 5'd0);
        step();
        drive(8'h22, 1'b1, 5'd4, 5'd0, 5'd0);
        #1;
        check("lu0_stall_id", pif.stall_id, 1'b0);
        step();
        idle();
        check("lu0_valid_ex", pif.valid_ex, 1'b1);
        check("lu0_bubble_cnt", pif.bubble_cnt, 16'd0);

        // Flush squashes ID but lets the EX instruction move on.
        reset_dut();
        drive(8'h20, 1'b1, 5'd7, 5'd0, 5'd0);
        step();
        drive(8'hA2, 1'b1, 5'd9, 5'd0, 5'd0);
        pif.flush_ex = 1'b1;
        #1;
        check("fl_stall_id", pif.stall_id, 1'b0);
        step();
        idle();
        check("fl_valid_ex", pif.valid_ex, 1'b0);
        check("fl_mem", {pif.valid_mem, pif.rd_mem}, {1'b1, 5'd7});
        check("fl_bubble_cnt", pif.bubble_cnt, 16'd1);

        // Flush and stall together: one bubble, no stall.
        cnt_before = int'(pif.bubble_cnt);
        drive(8'hA2, 1'b1, 5'd9, 5'd0, 5'd0);
        pif.flush_ex = 1'b1;
        pif.stall_in = 1'b1;
        #1;
        check("pri_stall_id", pif.stall_id, 1'b0);
        step();
        idle();
        check("pri_bubble_cnt", pif.bubble_cnt, 16'(cnt_before + 1));
        check("pri_valid_ex", pif.valid_ex, 1'b0);

        // Async reset mid-stream with every stage valid.
        drive(8'hF0, 1'b1, 5'd1, 5'd0, 5'd0);
        step();
        drive(8'h20, 1'b1, 5'd2, 5'd0, 5'd0);
        step();
        drive(8'hA2, 1'b1, 5'd3, 5'd0, 5'd0);
        step();
        check("ar_all_valid", {pif.valid_ex, pif.valid_mem, pif.valid_wb}, 3'b111);
        #2;
        pif.stall_in = 1'b1;
        rst = 1'b1;
        #1;
        check("ar_valid", {pif.valid_ex, pif.valid_mem, pif.valid_wb}, 3'b000);
        check("ar_rd", {pif.rd_ex, pif.rd_mem, pif.rd_wb}, 15'd0);
        check("ar_ctrl", {pif.alusrc_ex, pif.aluop_ex, pif.branch_ex, pif.memread_mem,
                          pif.memwrite_mem, pif.memtoreg_wb, pif.regwrite_wb}, 8'h00);
        check("ar_bubble_cnt", pif.bubble_cnt, 16'd0);
        check("ar_stall_id", pif.stall_id, 1'b0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        idle();
        step();
        check("ar_empty_after", {pif.valid_ex, pif.valid_mem, pif.valid_wb}, 3'b000);
        drive(8'h20, 1'b1, 5'd6, 5'd0, 5'd0);
        step();
        idle();
        check("ar_first_valid", {pif.valid_ex, pif.rd_ex, pif.valid_mem}, {1'b1, 5'd6, 1'b0});
        step();
        step();
        check("ar_no_ghost", {pif.valid_ex, pif.valid_mem, pif.valid_wb}, 3'b001);

        // Saturation of the bubble counter.
        reset_dut();
        pif.stall_in = 1'b1;
        drive(8'h20, 1'b1, 5'd8, 5'd0, 5'd0);
        repeat (65540) step();
        check("sat_cnt", pif.bubble_cnt, 16'hFFFF);
        check("sat_stall_id", pif.stall_id, 1'b1);
        repeat (3) step();
        check("sat_hold", pif.bubble_cnt, 16'hFFFF);
        idle();
        step();

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
